conv_fprop1_mul_sched: RTL and testbench

CONV_FPROP1_MUL_SCHED -- requirements
Module: conv_fprop1_mul_sched

---
 rtl/conv_fprop1_sched_pkg.sv | 19 +
 rtl/conv_fprop1_rr_arb.sv | 34 +++
 rtl/conv_fprop1_mul_sched.sv | 120 ++++++++++++
 tb/tb_conv_fprop1_mul_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_fprop1_sched_pkg.sv
// Shared constants and types for the fprop1 multiplier scheduler.
package conv_fprop1_sched_pkg;

    localparam int DEF_NREQ   = 4;
    localparam int DEF_DATA_W = 10;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_e;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ID_W = id_w(DEF_NREQ);

endpackage

// File: rtl/conv_fprop1_rr_arb.sv
// Round-robin pick: first asserted request at or after the pointer, wrapping.
module conv_fprop1_rr_arb
    import conv_fprop1_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int ID_W = id_w(NREQ)
)(
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx
);

    logic [ID_W-1:0] idx;
    logic            found;

    // NREQ is a power of two, so the ID_W-bit add wraps modulo NREQ for free.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = ptr + k[ID_W-1:0];
            if (en && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = idx;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_fprop1_mul_sched.sv
// Shares one signed multiplier among NREQ requesters behind a one-entry result buffer.
// state    | meaning
// ST_EMPTY | no result held; any valid requester may be granted
// ST_FULL  | result held on res_*; a grant needs res_ready to free the slot
module conv_fprop1_mul_sched
    import conv_fprop1_sched_pkg::*;
#(
    parameter int  NREQ   = DEF_NREQ,
    parameter int  DATA_W = DEF_DATA_W,
    parameter int  CNT_W  = DEF_CNT_W,
    localparam int ID_W   = id_w(NREQ)
)(
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [DATA_W-1:0]      res_data,
    output logic [ID_W-1:0]        res_id,
    output logic                   res_ovf,
    output logic [CNT_W-1:0]       op_count,
    output logic                   busy
);

    buf_state_e                 state_q, state_d;
    logic [ID_W-1:0]            ptr_q, ptr_d;
    logic [DATA_W-1:0]          data_q, data_d;
    logic [ID_W-1:0]            id_q, id_d;
    logic                       ovf_q, ovf_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic                       arb_en;
    logic [NREQ-1:0]            grant;
    logic [ID_W-1:0]            grant_idx;
    logic                       any_grant;
    logic                       xfer;
    logic signed [DATA_W-1:0]   op_a, op_b;
    logic signed [2*DATA_W-1:0] prod;
    logic [DATA_W:0]            prod_hi;

    // Gating on reset keeps req_ready low while ap_rst_n is asserted.
    assign arb_en    = ap_rst_n && ((state_q == ST_EMPTY) || res_ready);
    assign any_grant = |grant;
    assign xfer      = (state_q == ST_FULL) && res_ready;

    conv_fprop1_rr_arb #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .en        (arb_en),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                op_a = req_a[i*DATA_W +: DATA_W];
                op_b = req_b[i*DATA_W +: DATA_W];
            end
        end
        prod    = op_a * op_b;
        prod_hi = prod[2*DATA_W-1:DATA_W-1];
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, xfer};
        case (state_q)
            ST_EMPTY: if (any_grant) state_d = ST_FULL;
            ST_FULL:  if (xfer && !any_grant) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
        if (any_grant) begin
            ptr_d  = grant_idx + ID_W'(1);
            data_d = prod[DATA_W-1:0];
            id_d   = grant_idx;
            // Representable iff the sign bit of the truncated result is replicated above it.
            ovf_d  = !((&prod_hi) || !(|prod_hi));
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready = grant;
    assign res_valid = (state_q == ST_FULL);
    assign busy      = res_valid;
    assign res_data  = data_q;
    assign res_id    = id_q;
    assign res_ovf   = ovf_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_conv_fprop1_mul_sched.sv
// Randomized and directed checks of conv_fprop1_mul_sched against a queue-level model.
module tb_conv_fprop1_mul_sched;

    localparam int NREQ = 4;
    localparam int DW   = 10;
    localparam int CW   = 16;
    localparam int IW   = 2;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DW-1:0]   req_a, req_b;
    logic                 res_valid, res_ready;
    logic [DW-1:0]        res_data;
    logic [IW-1:0]        res_id;
    logic                 res_ovf;
    logic [CW-1:0]        op_count;
    logic                 busy;

    always #5 ap_clk = ~ap_clk;

    conv_fprop1_mul_sched dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf),
        .op_count  (op_count),
        .busy      (busy)
    );

    // Model: pending-result slot, round-robin pointer, results accepted since reset.
    int          m_ptr;
    bit          m_full;
    logic [DW-1:0] m_data;
    int          m_id;
    bit          m_ovf;
    int          m_cnt;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_grant();
        if (!ap_rst_n) return -1;
        if (m_full && !res_ready) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        int g;
        g = exp_grant();
        chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        chk("res_valid", 32'(res_valid), 32'(m_full));
        chk("busy", 32'(busy), 32'(m_full));
        chk("op_count", 32'(op_count), 32'(m_cnt % 65536));
        if (m_full) begin
            chk("res_data", 32'(res_data), 32'(m_data));
            chk("res_id", 32'(res_id), 32'(m_id));
            chk("res_ovf", 32'(res_ovf), 32'(m_ovf));
        end
    endtask

    task automatic model_reset();
        m_full = 0; m_ptr = 0; m_cnt = 0; m_data = '0; m_id = 0; m_ovf = 0;
    endtask

    // Inputs are set just after a falling edge; check, take the rising edge, return at the next falling edge.
    task automatic cycle();
        int g, p;
        logic signed [DW-1:0] sa, sb;
        bit xf;
        #1;
        check_outputs();
        g  = exp_grant();
        xf = m_full && res_ready && ap_rst_n;
        sa = '0; sb = '0;
        if (g >= 0) begin
            sa = req_a[g*DW +: DW];
            sb = req_b[g*DW +: DW];
        end
        p = int'(sa) * int'(sb);
        @(posedge ap_clk);
        if (!ap_rst_n) begin
            model_reset();
        end else begin
            if (xf) m_cnt++;
            if (g >= 0) begin
                m_full = 1;
                m_data = p[DW-1:0];
                m_id   = g;
                m_ovf  = (p < -(1 << (DW-1))) || (p > (1 << (DW-1)) - 1);
                m_ptr  = (g + 1) % NREQ;
            end else if (xf) begin
                m_full = 0;
            end
        end
        @(negedge ap_clk);
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*DW +: DW] = a[DW-1:0];
        req_b[i*DW +: DW] = b[DW-1:0];
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        cycle();
        ap_rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        ap_rst_n  = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
        model_reset();
        @(posedge ap_clk);
        @(negedge ap_clk);

        // Reset state, with requests pending to show req_ready stays low.
        req_valid = '1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_res_ovf", 32'(res_ovf), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        @(negedge ap_clk);
        req_valid = '0;
        ap_rst_n  = 1'b1;

        // Basic multiply: 3 * -4.
        set_op(0, 3, -4);
        req_valid = 4'b0001;
        cycle();
        req_valid = '0;
        #1;
        chk("basic_valid", 32'(res_valid), 32'd1);
        chk("basic_data", 32'(res_data), 32'h3F4);
        chk("basic_id", 32'(res_id), 32'd0);
        chk("basic_ovf", 32'(res_ovf), 32'd0);
        cycle();
        #1;
        chk("basic_count", 32'(op_count), 32'd1);

        // Overflow cases, granted to requester 1 then 2 by the rotating pointer.
        set_op(1, 100, 10);
        req_valid = 4'b0010;
        cycle();
        set_op(2, -512, 1);
        req_valid = 4'b0100;
        #1;
        chk("ovf1_data", 32'(res_data), 32'h3E8);
        chk("ovf1_ovf", 32'(res_ovf), 32'd1);
        cycle();
        req_valid = '0;
        #1;
        chk("ovf2_data", 32'(res_data), 32'h200);
        chk("ovf2_ovf", 32'(res_ovf), 32'd0);
        chk("ovf2_id", 32'(res_id), 32'd2);
        cycle();

        // Fairness: all valid, consumer always ready.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 7);
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("fair_grant", 32'(req_ready), 32'd1 << (k % 4));
            chk("fair_count", 32'(op_count), (k == 0) ? 32'd0 : 32'(k - 1));
            cycle();
        end

        // Backpressure: hold the result 3 cycles, then release.
        do_reset();
        set_op(0, -7, 9);
        req_valid = '1;
        cycle();
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_data", 32'(res_data), 32'h3C1);
            chk("bp_id", 32'(res_id), 32'd0);
            cycle();
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(req_ready), 32'd2);
        cycle();
        #1;
        chk("bp_still_full", 32'(res_valid), 32'd1);
        chk("bp_count", 32'(op_count), 32'd1);
        chk("bp_new_id", 32'(res_id), 32'd1);

        // Reset mid-operation with pointer at 2 and a result held.
        do_reset();
        req_valid = '1;
        cycle();
        cycle();
        res_ready = 1'b0;
        ap_rst_n  = 1'b0;
        cycle();
        ap_rst_n  = 1'b1;
        res_ready = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_count", 32'(op_count), 32'd0);
        chk("mid_rst_grant", 32'(req_ready), 32'd1);
        cycle();

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 4000; k++) begin
            ap_rst_n  = ($urandom_range(0, 199) != 0);
            req_valid = NREQ'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++)
                set_op(i, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
            cycle();
        end

        // Counter wrap after 65536 accepted results.
        ap_rst_n = 1'b1;
        do_reset();
        req_valid = '1;
        res_ready = 1'b1;
        guard = 0;
        while (m_cnt < 65536 && guard < 70000) begin
            cycle();
            guard++;
        end
        chk("wrap_budget", 32'(m_cnt), 32'd65536);
        #1;
        chk("wrap_0", 32'(op_count), 32'd0);
        cycle();
        #1;
        chk("wrap_1", 32'(op_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
